uart_cmd_ctrl: RTL and testbench

- Command sequencer sitting behind the UART receiver in the system clock domain.
- Consumes validated RX bytes (the rx_valid pulse from the UART RX), decodes multi-byte command frames, and sequences register-file writes/reads and ALU operations.
- Returns read data and ALU results as bytes to the UART transmitter through a valid/ready handshake.
- Also gates the ALU clock enable so the ALU only toggles during an operation (low-power).

---
 rtl/uart_cmd_pkg.sv | 38 +++
 rtl/uart_cmd_timeout.sv | 35 +++
 rtl/uart_cmd_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared opcodes, state encoding and fixed operand addresses for the UART
// command sequencer.
package uart_cmd_pkg;

    localparam logic [7:0] CMD_WR      = 8'hAA;
    localparam logic [7:0] CMD_RD      = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam int OPA_ADDR = 0;
    localparam int OPB_ADDR = 1;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_WR_ADDR  = 4'd1,
        ST_WR_DATA  = 4'd2,
        ST_RD_ADDR  = 4'd3,
        ST_RD_WAIT  = 4'd4,
        ST_OP_A     = 4'd5,
        ST_OP_B     = 4'd6,
        ST_ALU_FUN  = 4'd7,
        ST_ALU_WAIT = 4'd8,
        ST_TX_RD    = 4'd9,
        ST_TX_LO    = 4'd10,
        ST_TX_HI    = 4'd11
    } state_e;

    // States in which a new RX byte cannot be consumed and counts as overrun.
    function automatic logic is_busy_state(input state_e s);
        return s inside {ST_RD_WAIT, ST_ALU_WAIT, ST_TX_RD, ST_TX_LO, ST_TX_HI};
    endfunction

    // States that are waiting for the next byte of a partially received frame.
    function automatic logic is_frame_state(input state_e s);
        return s inside {ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR, ST_OP_A, ST_OP_B, ST_ALU_FUN};
    endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timeout counter: cleared by clr_i, counts while en_i, held at zero
// otherwise; expire_o flags the cycle the count reaches TIMEOUT_CYC-1.
module uart_cmd_timeout #(
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expire_o = en_i && !clr_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || !en_i || expire_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command sequencer: decodes RX command frames into register-file and ALU
// transactions and returns results as TX bytes. Define CMD_TIMEOUT_EN for the inter-byte timeout.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 4,
    parameter int FUN_W       = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     rx_data,
    input  logic                  rx_valid,
    output logic                  rf_wr_en,
    output logic                  rf_rd_en,
    output logic [ADDR_W-1:0]     rf_addr,
    output logic [DATA_W-1:0]     rf_wr_data,
    input  logic [DATA_W-1:0]     rf_rd_data,
    input  logic                  rf_rd_valid,
    output logic                  alu_clk_en,
    output logic                  alu_en,
    output logic [FUN_W-1:0]      alu_fun,
    input  logic [2*DATA_W-1:0]   alu_out,
    input  logic                  alu_valid,
    output logic [DATA_W-1:0]     tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  cmd_err,
    output logic [3:0]            dbg_state
);

    // TX handshake: a byte transfers on a rising edge where tx_valid and tx_ready
    // are both high; until then tx_valid stays high and tx_data does not change.

    state_e              state_q, state_d;
    logic                rf_wr_en_q, rf_wr_en_d;
    logic                rf_rd_en_q, rf_rd_en_d;
    logic [ADDR_W-1:0]   rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0]   rf_wr_data_q, rf_wr_data_d;
    logic                alu_clk_en_q, alu_clk_en_d;
    logic                alu_en_q, alu_en_d;
    logic                alu_start_q, alu_start_d;
    logic [FUN_W-1:0]    alu_fun_q, alu_fun_d;
    logic [DATA_W-1:0]   res_hi_q, res_hi_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic                cmd_err_q, cmd_err_d;
    logic                tx_done;
    logic                timeout_hit;

    assign tx_done = tx_valid_q && tx_ready;

`ifdef CMD_TIMEOUT_EN
    logic frame_active;
    assign frame_active = is_frame_state(state_q);

    uart_cmd_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (rx_valid),
        .en_i     (frame_active),
        .expire_o (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        rf_wr_en_d   = 1'b0;
        rf_rd_en_d   = 1'b0;
        rf_addr_d    = rf_addr_q;
        rf_wr_data_d = rf_wr_data_q;
        alu_clk_en_d = alu_clk_en_q;
        alu_en_d     = alu_start_q;
        alu_start_d  = 1'b0;
        alu_fun_d    = alu_fun_q;
        res_hi_d     = res_hi_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        cmd_err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == DATA_W'(CMD_WR)) begin
                        state_d = ST_WR_ADDR;
                    end else if (rx_data == DATA_W'(CMD_RD)) begin
                        state_d = ST_RD_ADDR;
                    end else if (rx_data == DATA_W'(CMD_ALU_OP)) begin
                        state_d = ST_OP_A;
                    end else if (rx_data == DATA_W'(CMD_ALU_NOP)) begin
                        state_d = ST_ALU_FUN;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end
            ST_WR_ADDR: begin
                if (rx_valid) begin
                    rf_addr_d = rx_data[ADDR_W-1:0];
                    state_d   = ST_WR_DATA;
                end
            end
            ST_WR_DATA: begin
                if (rx_valid) begin
                    rf_wr_en_d   = 1'b1;
                    rf_wr_data_d = rx_data;
                    state_d      = ST_IDLE;
                end
            end
            ST_RD_ADDR: begin
                if (rx_valid) begin
                    rf_addr_d  = rx_data[ADDR_W-1:0];
                    rf_rd_en_d = 1'b1;
                    state_d    = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (rf_rd_valid) begin
                    tx_data_d  = rf_rd_data;
                    tx_valid_d = 1'b1;
                    state_d    = ST_TX_RD;
                end
            end
            ST_OP_A: begin
                if (rx_valid) begin
                    rf_addr_d    = ADDR_W'(OPA_ADDR);
                    rf_wr_data_d = rx_data;
                    rf_wr_en_d   = 1'b1;
                    state_d      = ST_OP_B;
                end
            end
            ST_OP_B: begin
                if (rx_valid) begin
                    rf_addr_d    = ADDR_W'(OPB_ADDR);
                    rf_wr_data_d = rx_data;
                    rf_wr_en_d   = 1'b1;
                    state_d      = ST_ALU_FUN;
                end
            end
            ST_ALU_FUN: begin
                // Clock gate opens first; alu_en follows one cycle later once it has settled.
                if (rx_valid) begin
                    alu_clk_en_d = 1'b1;
                    alu_fun_d    = rx_data[FUN_W-1:0];
                    alu_start_d  = 1'b1;
                    state_d      = ST_ALU_WAIT;
                end
            end
            ST_ALU_WAIT: begin
                // Low result byte goes straight into tx_data; the high byte waits in res_hi_q.
                if (alu_valid) begin
                    res_hi_d     = alu_out[2*DATA_W-1:DATA_W];
                    tx_data_d    = alu_out[DATA_W-1:0];
                    tx_valid_d   = 1'b1;
                    alu_clk_en_d = 1'b0;
                    state_d      = ST_TX_LO;
                end
            end
            ST_TX_RD: begin
                if (tx_done) begin
                    tx_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            ST_TX_LO: begin
                if (tx_done) begin
                    tx_data_d = res_hi_q;
                    state_d   = ST_TX_HI;
                end
            end
            ST_TX_HI: begin
                if (tx_done) begin
                    tx_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (rx_valid && is_busy_state(state_q)) begin
            cmd_err_d = 1'b1;
        end

        if (timeout_hit) begin
            state_d      = ST_IDLE;
            cmd_err_d    = 1'b1;
            alu_clk_en_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            rf_wr_en_q   <= 1'b0;
            rf_rd_en_q   <= 1'b0;
            rf_addr_q    <= '0;
            rf_wr_data_q <= '0;
            alu_clk_en_q <= 1'b0;
            alu_en_q     <= 1'b0;
            alu_start_q  <= 1'b0;
            alu_fun_q    <= '0;
            res_hi_q     <= '0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            cmd_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rf_wr_en_q   <= rf_wr_en_d;
            rf_rd_en_q   <= rf_rd_en_d;
            rf_addr_q    <= rf_addr_d;
            rf_wr_data_q <= rf_wr_data_d;
            alu_clk_en_q <= alu_clk_en_d;
            alu_en_q     <= alu_en_d;
            alu_start_q  <= alu_start_d;
            alu_fun_q    <= alu_fun_d;
            res_hi_q     <= res_hi_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            cmd_err_q    <= cmd_err_d;
        end
    end

    assign rf_wr_en   = rf_wr_en_q;
    assign rf_rd_en   = rf_rd_en_q;
    assign rf_addr    = rf_addr_q;
    assign rf_wr_data = rf_wr_data_q;
    assign alu_clk_en = alu_clk_en_q;
    assign alu_en     = alu_en_q;
    assign alu_fun    = alu_fun_q;
    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign cmd_err    = cmd_err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: directed frames from the test plan plus
// randomized frames checked against a frame-level reference model.
module tb_uart_cmd_ctrl;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int FUN_W  = 4;
`ifdef CMD_TIMEOUT_EN
    localparam int TO_CYC = 100;
`else
    localparam int TO_CYC = 65535;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rf_wr_en, rf_rd_en;
    logic [3:0]  rf_addr;
    logic [7:0]  rf_wr_data;
    logic [7:0]  rf_rd_data;
    logic        rf_rd_valid;
    logic        alu_clk_en, alu_en;
    logic [3:0]  alu_fun;
    logic [15:0] alu_out;
    logic        alu_valid;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready;
    logic        cmd_err;
    logic [3:0]  dbg_state;

    always #5 clk = ~clk;

    uart_cmd_ctrl #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .FUN_W       (FUN_W),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rf_wr_en    (rf_wr_en),
        .rf_rd_en    (rf_rd_en),
        .rf_addr     (rf_addr),
        .rf_wr_data  (rf_wr_data),
        .rf_rd_data  (rf_rd_data),
        .rf_rd_valid (rf_rd_valid),
        .alu_clk_en  (alu_clk_en),
        .alu_en      (alu_en),
        .alu_fun     (alu_fun),
        .alu_out     (alu_out),
        .alu_valid   (alu_valid),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .cmd_err     (cmd_err),
        .dbg_state   (dbg_state)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // ---------------- reference model / scoreboard ----------------
    logic [7:0]  model_rf [16];
    logic [7:0]  env_rf   [16];
    logic [15:0] exp_wr_q[$], got_wr_q[$];
    logic [3:0]  exp_rd_q[$], got_rd_q[$];
    logic [3:0]  exp_alu_q[$], got_alu_q[$];
    logic [7:0]  exp_tx_q[$], got_tx_q[$];
    int          exp_err = 0;
    int          got_err = 0;

    function automatic logic [15:0] alu_ref(input logic [3:0] fun, input logic [7:0] a, input logic [7:0] b);
        case (fun[1:0])
            2'd0:    return 16'(a) * 16'(b);
            2'd1:    return 16'(a) - 16'(b);
            2'd2:    return 16'(a) + 16'(b);
            default: return {a ^ b, b};
        endcase
    endfunction

    function automatic void model_frame(input logic [7:0] op, input logic [7:0] b1,
                                        input logic [7:0] b2, input logic [7:0] b3);
        logic [15:0] r;
        case (op)
            8'hAA: begin
                exp_wr_q.push_back({4'h0, b1[3:0], b2});
                model_rf[b1[3:0]] = b2;
            end
            8'hBB: begin
                exp_rd_q.push_back(b1[3:0]);
                exp_tx_q.push_back(model_rf[b1[3:0]]);
            end
            8'hCC: begin
                exp_wr_q.push_back({8'h00, b1});
                exp_wr_q.push_back({8'h01, b2});
                model_rf[0] = b1;
                model_rf[1] = b2;
                r = alu_ref(b3[3:0], b1, b2);
                exp_alu_q.push_back(b3[3:0]);
                exp_tx_q.push_back(r[7:0]);
                exp_tx_q.push_back(r[15:8]);
            end
            8'hDD: begin
                r = alu_ref(b1[3:0], model_rf[0], model_rf[1]);
                exp_alu_q.push_back(b1[3:0]);
                exp_tx_q.push_back(r[7:0]);
                exp_tx_q.push_back(r[15:8]);
            end
            default: exp_err++;
        endcase
    endfunction

    // ---------------- monitor ----------------
    int          cyc = 0;
    int          clk_en_rise_cyc = 0;
    logic        prev_clk_en = 1'b0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_tx = 8'h00;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            prev_stall  = 1'b0;
            prev_clk_en = 1'b0;
        end else begin
            if (rf_wr_en) begin
                got_wr_q.push_back({4'h0, rf_addr, rf_wr_data});
                env_rf[rf_addr] = rf_wr_data;
            end
            if (rf_rd_en) got_rd_q.push_back(rf_addr);
            if (alu_clk_en && !prev_clk_en) clk_en_rise_cyc = cyc;
            if (alu_en) begin
                got_alu_q.push_back(alu_fun);
                check("alu_en_after_clk_en", cyc - clk_en_rise_cyc, 1);
                check("clk_en_at_alu_en", alu_clk_en, 1);
            end
            prev_clk_en = alu_clk_en;
            if (cmd_err) got_err++;
            if (prev_stall) begin
                check("tx_hold_valid", tx_valid, 1);
                check("tx_hold_data", tx_data, prev_tx);
            end
            if (tx_valid && tx_ready) got_tx_q.push_back(tx_data);
            prev_stall = tx_valid && !tx_ready;
            prev_tx    = tx_data;
        end
    end

    // ---------------- transmitter model ----------------
    bit tx_stall = 1'b0;

    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tx_ready = tx_stall ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    function automatic int get_cnt(input int sel);
        if (sel == 0) return got_rd_q.size();
        if (sel == 1) return got_alu_q.size();
        return got_tx_q.size();
    endfunction

    task automatic wait_cnt(input string tag, input int sel, input int target);
        int i = 0;
        while (get_cnt(sel) < target && i < 300) begin
            tick();
            i++;
        end
        if (get_cnt(sel) < target) check({"timeout_", tag}, get_cnt(sel), target);
    endtask

    task automatic clear_all();
        exp_wr_q.delete(); got_wr_q.delete();
        exp_rd_q.delete(); got_rd_q.delete();
        exp_alu_q.delete(); got_alu_q.delete();
        exp_tx_q.delete(); got_tx_q.delete();
        exp_err = 0;
        got_err = 0;
    endtask

    task automatic compare_queues();
        check("wr_count", got_wr_q.size(), exp_wr_q.size());
        while (exp_wr_q.size() > 0 && got_wr_q.size() > 0)
            check("wr_item", got_wr_q.pop_front(), exp_wr_q.pop_front());
        check("rd_count", got_rd_q.size(), exp_rd_q.size());
        while (exp_rd_q.size() > 0 && got_rd_q.size() > 0)
            check("rd_addr", got_rd_q.pop_front(), exp_rd_q.pop_front());
        check("alu_count", got_alu_q.size(), exp_alu_q.size());
        while (exp_alu_q.size() > 0 && got_alu_q.size() > 0)
            check("alu_fun", got_alu_q.pop_front(), exp_alu_q.pop_front());
        check("tx_count", got_tx_q.size(), exp_tx_q.size());
        while (exp_tx_q.size() > 0 && got_tx_q.size() > 0)
            check("tx_byte", got_tx_q.pop_front(), exp_tx_q.pop_front());
        check("err_count", got_err, exp_err);
        clear_all();
    endtask

    // Drives one frame, plays the register file / ALU side, and scores the result.
    task automatic run_frame(input logic [7:0] op, input logic [7:0] b1, input logic [7:0] b2,
                             input logic [7:0] b3, input bit overrun, input bit stall);
        int          nb;
        logic [7:0]  bytes [4];
        model_frame(op, b1, b2, b3);
        case (op)
            8'hAA:   nb = 3;
            8'hBB:   nb = 2;
            8'hCC:   nb = 4;
            8'hDD:   nb = 2;
            default: nb = 1;
        endcase
        bytes[0] = op; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
        if (stall) tx_stall = 1'b1;
        for (int i = 0; i < nb; i++) begin
            send_byte(bytes[i]);
            repeat ($urandom_range(0, 3)) tick();
        end
        if (op == 8'hBB) begin
            wait_cnt("rd_en", 0, 1);
            repeat ($urandom_range(0, 3)) tick();
            if (overrun) begin
                send_byte(8'($urandom));
                exp_err++;
            end
            rf_rd_data  = (got_rd_q.size() > 0) ? env_rf[got_rd_q[$]] : 8'h00;
            rf_rd_valid = 1'b1;
            tick();
            rf_rd_valid = 1'b0;
        end else if (op == 8'hCC || op == 8'hDD) begin
            wait_cnt("alu_en", 1, 1);
            repeat ($urandom_range(0, 4)) tick();
            if (overrun) begin
                send_byte(8'($urandom));
                exp_err++;
            end
            alu_out   = alu_ref((got_alu_q.size() > 0) ? got_alu_q[$] : 4'h0, env_rf[0], env_rf[1]);
            alu_valid = 1'b1;
            tick();
            alu_valid = 1'b0;
        end
        if (stall) begin
            int w = 0;
            while (!tx_valid && w < 100) begin
                tick();
                w++;
            end
            repeat (10) tick();
            check("stall_tx_valid", tx_valid, 1);
            check("stall_tx_data", tx_data, (exp_tx_q.size() > 0) ? exp_tx_q[0] : 8'h00);
            tx_stall = 1'b0;
        end
        wait_cnt("tx", 2, exp_tx_q.size());
        repeat (3) tick();
        check("clk_en_low_after_frame", alu_clk_en, 0);
        check("idle_after_frame", dbg_state, 0);
        compare_queues();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset       = 1'b1;
        rx_valid    = 1'b0;
        rx_data     = 8'h00;
        rf_rd_valid = 1'b0;
        rf_rd_data  = 8'h00;
        alu_valid   = 1'b0;
        alu_out     = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            model_rf[i] = 8'h00;
            env_rf[i]   = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        @(negedge clk);
        check("rst_rf_wr_en", rf_wr_en, 0);
        check("rst_rf_rd_en", rf_rd_en, 0);
        check("rst_rf_addr", rf_addr, 0);
        check("rst_rf_wr_data", rf_wr_data, 0);
        check("rst_alu_clk_en", alu_clk_en, 0);
        check("rst_alu_en", alu_en, 0);
        check("rst_alu_fun", alu_fun, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_cmd_err", cmd_err, 0);
        check("rst_state", dbg_state, 0);
        tick();

        // Directed write: strobe must appear the cycle after the data byte.
        model_frame(8'hAA, 8'h05, 8'h3C, 8'h00);
        send_byte(8'hAA);
        send_byte(8'h05);
        send_byte(8'h3C);
        @(negedge clk);
        check("wr_en_strobe", rf_wr_en, 1);
        check("wr_addr", rf_addr, 5);
        check("wr_data", rf_wr_data, 8'h3C);
        check("wr_no_tx", tx_valid, 0);
        tick();
        repeat (3) tick();
        compare_queues();

        // Directed read of 0x9E from address 7 with a stalled transmitter.
        run_frame(8'hAA, 8'h07, 8'h9E, 8'h00, 1'b0, 1'b0);
        run_frame(8'hBB, 8'h07, 8'h00, 8'h00, 1'b0, 1'b1);

        // Directed ALU with operands plus an overrun byte in ALU_WAIT.
        run_frame(8'hCC, 8'h12, 8'h34, 8'h02, 1'b1, 1'b0);

        // Illegal opcode.
        run_frame(8'h55, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

        // Reset while the low result byte is waiting in TX_LO.
        tx_stall = 1'b1;
        send_byte(8'hDD);
        send_byte(8'h03);
        wait_cnt("rst_alu_en", 1, 1);
        alu_out   = 16'hBEEF;
        alu_valid = 1'b1;
        tick();
        alu_valid = 1'b0;
        begin
            int w = 0;
            while (!tx_valid && w < 50) begin
                tick();
                w++;
            end
        end
        check("pre_rst_tx_valid", tx_valid, 1);
        reset = 1'b1;
        #1;
        check("midrst_tx_valid", tx_valid, 0);
        check("midrst_alu_clk_en", alu_clk_en, 0);
        check("midrst_state", dbg_state, 0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        clear_all();
        tx_stall = 1'b0;
        run_frame(8'hDD, 8'($urandom), 8'h00, 8'h00, 1'b0, 1'b0);

        // Randomized frames, with overruns, stalls and stray result pulses.
        for (int f = 0; f < 40; f++) begin
            int         sel;
            logic [7:0] op;
            bit         resp;
            sel = $urandom_range(0, 9);
            if (sel < 3)      op = 8'hAA;
            else if (sel < 5) op = 8'hBB;
            else if (sel < 7) op = 8'hCC;
            else if (sel < 9) op = 8'hDD;
            else begin
                op = 8'($urandom);
                while (op == 8'hAA || op == 8'hBB || op == 8'hCC || op == 8'hDD) op = 8'($urandom);
            end
            resp = (op == 8'hBB || op == 8'hCC || op == 8'hDD);
            run_frame(op, 8'($urandom), 8'($urandom), 8'($urandom),
                      resp && ($urandom_range(0, 3) == 0), resp && ($urandom_range(0, 4) == 0));
            if ($urandom_range(0, 2) == 0) begin
                rf_rd_data  = 8'($urandom);
                rf_rd_valid = 1'b1;
                alu_out     = 16'($urandom);
                alu_valid   = 1'b1;
                tick();
                rf_rd_valid = 1'b0;
                alu_valid   = 1'b0;
                repeat (2) tick();
                check("stray_valid_idle", dbg_state, 0);
                compare_queues();
            end
        end

`ifdef CMD_TIMEOUT_EN
        // Partial frame followed by silence must time out TO_CYC edges after the opcode.
        begin
            int k = 0;
            send_byte(8'hAA);
            exp_err++;
            do begin
                tick();
                k++;
            end while (!cmd_err && k < 200);
            check("timeout_cycle", k, TO_CYC);
            tick();
            check("timeout_idle", dbg_state, 0);
            compare_queues();
            run_frame(8'hAA, 8'h01, 8'h02, 8'h00, 1'b0, 1'b0);
        end
`endif

        repeat (5) tick();
        compare_queues();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
